// File: rtl/sd_read_buffer.sv
// Receive buffer for one 512-byte SD data block: deserialises bits MSB-first into
// 16-bit words, checks the trailing CRC16-CCITT and serves the sector through a registered read port.
module sd_read_buffer #(
    parameter int WORDS  = 256,
    parameter int ADDR_W = 8,
    parameter bit CRC_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data,
    output logic              busy,
    output logic              done,
    output logic              crc_ok,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(WORDS);

    typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W+3:0]   bit_cnt;
    logic [15:0]         shift, shift_nxt;
    logic [15:0]         crc, crc_nxt;
    logic [15:0]         mem [WORDS];
    logic                take, last_data, last_crc;

    // Bits only count while receiving; a start in the same cycle wins and drops the bit.
    assign take      = bit_valid && !start && (state == DATA || state == CRC);
    assign last_data = take && state == DATA && (&bit_cnt);
    assign last_crc  = take && state == CRC && (&bit_cnt[3:0]);

    assign shift_nxt = {shift[14:0], bit_in};
    assign crc_nxt   = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? 16'h1021 : 16'h0000);

    assign busy = (state == DATA) || (state == CRC);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = DATA;
        end else begin
            case (state)
                DATA:    if (last_data) state_nxt = CRC_EN ? CRC : DONE;
                CRC:     if (last_crc)  state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // NOTE: the storage array sits in the async-reset domain on purpose, so a reset
    // guarantees every word reads back as zero rather than leftover sector data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            shift    <= '0;
            crc      <= '0;
            word_cnt <= '0;
            crc_ok   <= 1'b0;
            rd_data  <= '0;
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else begin
            // NOTE: non-blocking read and write of mem in one block gives read-before-write
            // when rd_addr hits the word being completed this cycle.
            rd_data <= mem[rd_addr];
            if (start) begin
                bit_cnt  <= '0;
                shift    <= '0;
                crc      <= '0;
                word_cnt <= '0;
                crc_ok   <= 1'b0;
            end else if (take) begin
                shift   <= shift_nxt;
                bit_cnt <= bit_cnt + 1'b1;
                if (state == DATA) begin
                    crc <= crc_nxt;
                    if (&bit_cnt[3:0]) begin
                        mem[bit_cnt[ADDR_W+3:4]] <= shift_nxt;
                        if (word_cnt != FULL_CNT) word_cnt <= word_cnt + 1'b1;
                    end
                    if (last_data && !CRC_EN) crc_ok <= 1'b1;
                end else if (last_crc) begin
                    // shift now holds the received CRC, crc the value computed over the data.
                    crc_ok <= (shift_nxt == crc);
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_read_buffer.sv
// Directed bench for sd_read_buffer: zero/ones/ramp sectors, CRC good/bad,
// async reset mid-sector, abort-restart and a CRC-less instance.
module tb_sd_read_buffer;

    logic        clk = 1'b0;
    logic        reset, start, bit_in, bit_valid;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data0, rd_data1;
    logic        busy0, busy1, done0, done1, crc_ok0, crc_ok1;
    logic [8:0]  word_cnt0, word_cnt1;

    logic [15:0] sector [256];
    logic [15:0] ramp_crc;
    logic [15:0] rd_val;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    sd_read_buffer #(.WORDS(256), .ADDR_W(8), .CRC_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .rd_addr(rd_addr), .rd_data(rd_data0), .busy(busy0), .done(done0),
        .crc_ok(crc_ok0), .word_cnt(word_cnt0)
    );

    sd_read_buffer #(.WORDS(256), .ADDR_W(8), .CRC_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .rd_addr(rd_addr), .rd_data(rd_data1), .busy(busy1), .done(done1),
        .crc_ok(crc_ok1), .word_cnt(word_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_of_sector();
        logic [15:0] c = 16'h0000;
        logic        fb;
        for (int w = 0; w < 256; w++) begin
            for (int i = 15; i >= 0; i--) begin
                fb = c[15] ^ sector[w][i];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic fill(input int kind);
        for (int k = 0; k < 256; k++) begin
            case (kind)
                0:       sector[k] = 16'h0000;
                1:       sector[k] = 16'hFFFF;
                default: sector[k] = 16'(k * 16'h0101);
            endcase
        end
    endtask

    task automatic pulse_start(input logic v, input logic b);
        @(negedge clk);
        start = 1'b1; bit_valid = v; bit_in = b;
        @(negedge clk);
        start = 1'b0; bit_valid = 1'b0;
    endtask

    // Optional word-count check happens before the new bit is driven, i.e. after all previous bits landed.
    task automatic send_bit(input logic b, input int gap, input int exp_wc);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bit_valid = 1'b0;
        end
        @(negedge clk);
        if (exp_wc >= 0) check("word_cnt_step", 32'(word_cnt0), 32'(exp_wc));
        bit_in = b; bit_valid = 1'b1;
    endtask

    task automatic send_data(input int nbits, input int maxgap, input bit chk_wc);
        int w;
        int i;
        for (int n = 0; n < nbits; n++) begin
            w = n / 16;
            i = 15 - (n % 16);
            send_bit(sector[w][i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0,
                     chk_wc ? w : -1);
        end
    endtask

    task automatic send_crc(input logic [15:0] c);
        for (int i = 15; i >= 1; i--) send_bit(c[i], 0, -1);
        @(negedge clk);
        check("done_before_last_crc_bit", 32'(done0), 32'd0);
        bit_in = c[0]; bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        check("done_after_last_crc_bit", 32'(done0), 32'd1);
        check("busy_in_done", 32'(busy0), 32'd0);
    endtask

    task automatic read_word(input logic [7:0] a, output logic [15:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data0;
    endtask

    task automatic check_all(input string tag, input logic [15:0] exp);
        for (int a = 0; a < 256; a++) begin
            read_word(8'(a), rd_val);
            check(tag, 32'(rd_val), 32'(exp));
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; rd_addr = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_done", 32'(done0), 32'd0);
        check("reset_crc_ok", 32'(crc_ok0), 32'd0);
        check("reset_word_cnt", 32'(word_cnt0), 32'd0);
        check("reset_rd_data", 32'(rd_data0), 32'd0);
        reset = 1'b1;

        // Reset in the middle of a sector.
        fill(1);
        pulse_start(1'b0, 1'b0);
        send_data(100, 0, 1'b0);
        @(negedge clk);
        bit_valid = 1'b0;
        check("mid_busy", 32'(busy0), 32'd1);
        check("mid_word_cnt", 32'(word_cnt0), 32'd6);
        check("mid_rd_word0", 32'(rd_data0), 32'h0000FFFF);
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy0), 32'd0);
        check("arst_done", 32'(done0), 32'd0);
        check("arst_crc_ok", 32'(crc_ok0), 32'd0);
        check("arst_word_cnt", 32'(word_cnt0), 32'd0);
        check("arst_rd_data", 32'(rd_data0), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        read_word(8'h00, rd_val);
        check("arst_word0_cleared", 32'(rd_val), 32'h0000);
        read_word(8'h03, rd_val);
        check("arst_word3_cleared", 32'(rd_val), 32'h0000);
        check("arst_idle", 32'(busy0), 32'd0);

        // All-zero sector, CRC 0x0000.
        fill(0);
        pulse_start(1'b0, 1'b0);
        send_data(4096, 0, 1'b0);
        send_crc(16'h0000);
        check("zero_crc_ok", 32'(crc_ok0), 32'd1);
        check("zero_word_cnt", 32'(word_cnt0), 32'd256);
        check_all("zero_read", 16'h0000);

        // All-ones sector, good then bad CRC.
        fill(1);
        pulse_start(1'b0, 1'b0);
        send_data(4096, 0, 1'b0);
        send_crc(16'h7FA1);
        check("ones_crc_ok", 32'(crc_ok0), 32'd1);
        pulse_start(1'b0, 1'b0);
        check("restart_done_clear", 32'(done0), 32'd0);
        check("restart_crc_ok_clear", 32'(crc_ok0), 32'd0);
        check("restart_busy", 32'(busy0), 32'd1);
        send_data(4096, 0, 1'b0);
        send_crc(16'h7FA0);
        check("ones_bad_crc", 32'(crc_ok0), 32'd0);
        check("ones_bad_word_cnt", 32'(word_cnt0), 32'd256);
        check_all("ones_read", 16'hFFFF);

        // Ramp with random bit_valid gaps, word count checked at every bit.
        fill(2);
        ramp_crc = crc_of_sector();
        pulse_start(1'b0, 1'b0);
        send_data(4096, 3, 1'b1);
        send_crc(ramp_crc);
        check("ramp_crc_ok", 32'(crc_ok0), 32'd1);
        check("ramp_word_cnt_sat", 32'(word_cnt0), 32'd256);
        read_word(8'h05, rd_val);
        check("ramp_word5", 32'(rd_val), 32'h0505);
        read_word(8'h80, rd_val);
        check("ramp_word80", 32'(rd_val), 32'h8080);
        read_word(8'hFF, rd_val);
        check("ramp_wordFF", 32'(rd_val), 32'hFFFF);

        // Abort after 40 bits; the valid bit alongside the second start must be dropped.
        fill(1);
        pulse_start(1'b0, 1'b0);
        send_data(40, 0, 1'b0);
        pulse_start(1'b1, 1'b1);
        check("abort_word_cnt", 32'(word_cnt0), 32'd0);
        check("abort_busy", 32'(busy0), 32'd1);
        fill(2);
        send_data(4096, 0, 1'b0);
        send_crc(ramp_crc);
        check("abort_crc_ok", 32'(crc_ok0), 32'd1);
        read_word(8'h00, rd_val);
        check("abort_word0", 32'(rd_val), 32'h0000);
        read_word(8'h01, rd_val);
        check("abort_word1", 32'(rd_val), 32'h0101);
        read_word(8'h02, rd_val);
        check("abort_word2", 32'(rd_val), 32'h0202);

        // CRC-less instance finishes straight after the last data bit.
        pulse_start(1'b0, 1'b0);
        send_data(4095, 0, 1'b0);
        @(negedge clk);
        check("nocrc_done_early", 32'(done1), 32'd0);
        bit_in = sector[255][0]; bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        check("nocrc_done", 32'(done1), 32'd1);
        check("nocrc_crc_ok", 32'(crc_ok1), 32'd1);
        check("nocrc_busy", 32'(busy1), 32'd0);
        check("nocrc_word_cnt", 32'(word_cnt1), 32'd256);
        check("crc_inst_still_busy", 32'(busy0), 32'd1);
        check("crc_inst_not_done", 32'(done0), 32'd0);
        send_crc(ramp_crc);
        check("crc_inst_crc_ok", 32'(crc_ok0), 32'd1);
        check("nocrc_ignores_bits_done", 32'(done1), 32'd1);
        check("nocrc_ignores_bits_cnt", 32'(word_cnt1), 32'd256);
        check("nocrc_ignores_bits_ok", 32'(crc_ok1), 32'd1);
        @(negedge clk);
        rd_addr = 8'h05;
        @(negedge clk);
        check("nocrc_word5", 32'(rd_data1), 32'h0505);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_read_buffer.md
Name: sd_read_buffer

Overview:
Receive-side counterpart of the SD sector write path. Deserialises one 512-byte SD data block (4096 data bits plus 16 CRC bits) arriving one bit per qualified clock from the SD bus controller. Packs the bits into 256 x 16-bit words and checks the CRC16. Exposes the sector to the CPU/cache side through a random-access 16-bit read port, sitting between the SD controller's receive shifter and the storage hierarchy.

Parameters:
WORDS, 256, number of 16-bit words per sector (fixed to one 512-byte block)
ADDR_W, 8, word address width (log2 WORDS)
CRC_EN, 1, 1 = check the trailing 16 CRC bits; 0 = skip the CRC phase, crc_ok forced 1

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse: arm buffer for a new sector
bit_in  input  1  serial data bit from SD DAT0 sampler
bit_valid  input  1  bit_in is valid this cycle
rd_addr  input  ADDR_W  word address for read port
rd_data  output  16  word at rd_addr, registered
busy  output  1  high while in DATA or CRC state
done  output  1  high (level) once the full sector and CRC have been received
crc_ok  output  1  CRC compare result, valid when done=1
word_cnt  output  ADDR_W+1  number of complete words written so far in the current sector (0..256)

Behaviour:
- Reset (reset=0, async): state=IDLE; bit counter, shift register, crc, word_cnt=0; busy=0, done=0, crc_ok=0, rd_data=0; every storage word cleared to 0.
- States: IDLE, DATA, CRC, DONE.
- IDLE: start=1 moves to DATA and clears bit counter, word_cnt, and the crc register (to 0x0000). bit_valid is ignored.
- DATA, on each bit_valid=1 cycle:
  - shift register updates as {shift[14:0], bit_in}; bit counter increments.
  - The first bit of the sector lands in data[15] of word 0 (MSB-first). Words fill in ascending address order.
  - On the 16th bit of a word, the completed word, including the current bit_in, is written to mem[bit_cnt[11:4]] in the same cycle, and word_cnt increments.
  - crc is updated with bit_in using CRC16-CCITT, poly 0x1021, init 0, no reflection, no final XOR.
  - After bit 4096: go to CRC if CRC_EN=1, else go to DONE with crc_ok=1.
- CRC: the next 16 valid bits shift into a receive-CRC register, MSB first. After the 16th bit: go to DONE, with crc_ok=1 iff the received CRC equals the computed crc.
- DONE: done=1, busy=0. Stays until start, then restarts as in IDLE (done and crc_ok clear the following cycle).
- busy=1 exactly in DATA and CRC.
- bit_valid=0 cycles stall all counters; no timeout in this block.
- start while in DATA or CRC: abort and restart.
  - Counters and crc clear, state stays DATA, a bit_valid in the same cycle is discarded.
  - Already-written words are not cleared.
- Read port:
  - rd_data <= mem[rd_addr] on every posedge, 1-cycle latency, always enabled.
  - A read of the word being written in the same cycle returns the old value (read-before-write).
  - Reads during DATA return stale content for words not yet written. Consumers wait for done=1.
- word_cnt saturates at 256, not a wrap to 0, which is why it is ADDR_W+1 bits wide.

Test Plan:
- Reset mid-sector: assert reset=0 after 100 bits -> all outputs 0 immediately, state IDLE; rd_data of word 0 reads 0x0000 after release.
- 512 bytes of 0x00 plus CRC 0x0000 -> done=1 exactly on the cycle after the 16th CRC bit; crc_ok=1; word_cnt=256; all 256 reads return 0x0000.
- 512 bytes of 0xFF plus CRC 0x7FA1 -> crc_ok=1. Same data with CRC 0x7FA0 -> crc_ok=0, data still readable as 0xFFFF.
- Ramp pattern (word k = k*0x0101, MSB first) with random bit_valid gaps of 0-3 cycles -> rd_addr=0x05 returns 0x0505 one cycle later; word_cnt increments only on 16-bit boundaries.
- start pulse after 40 bits, then a full sector -> word 0 and word 1 hold new-sector values; done asserts once, after 4096+16 bits counted from the second start.
- CRC_EN=0, 4096 bits -> done=1 right after the last data bit, crc_ok=1, any subsequent bit_valid ignored.
